lut_banked: RTL and testbench

LUT_BANKED -- requirements
Module: lut_banked

---
 rtl/lut_banked.sv | 72 +++++++
 tb/tb_lut_banked.sv | 138 +++++++++++++
 2 files changed

// File: rtl/lut_banked.sv
// lut_banked: multi-port registered-read lookup table, zeroed by a hardware sweep after reset or clear
module lut_banked #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_PORTS  = 2
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             clear,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [NUM_PORTS-1:0]             rd_en,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  rd_addr,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  q,
    output logic [NUM_PORTS-1:0]             q_valid,
    output logic                             ready
);
    typedef enum logic {SWEEP = 1'b0, READY = 1'b1} state_t;
    state_t                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]           mem [2**ADDR_WIDTH];
    logic [NUM_PORTS*DATA_WIDTH-1:0] q_q, q_d;
    logic [NUM_PORTS-1:0]            qv_q, qv_d;
    logic                            wr_ok;
    assign wr_ok   = (state_q == READY) && !clear && wr_en;
    assign ready   = (state_q == READY);
    assign q       = q_q;
    assign q_valid = qv_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == SWEEP) begin
            cnt_d   = clear ? '0 : cnt_q + 1'b1;
            state_d = (!clear && cnt_q == '1) ? READY : SWEEP;
        end else if (clear) begin
            state_d = SWEEP;
            cnt_d   = '0;
        end
    end
    // write-first: a same-edge honoured write to the read address wins over the array
    always_comb begin
        q_d  = q_q;
        qv_d = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (state_q == READY && rd_en[p]) begin
                qv_d[p] = 1'b1;
                q_d[p*DATA_WIDTH +: DATA_WIDTH] = (wr_ok && wr_addr == rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH])
                    ? wr_data : mem[rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            q_q     <= '0;
            qv_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            qv_q    <= qv_d;
        end
    end
    always_ff @(posedge clk) begin
        if (state_q == SWEEP)
            mem[cnt_q] <= '0;
        else if (wr_ok)
            mem[wr_addr] <= wr_data;
    end
endmodule

// File: tb/tb_lut_banked.sv
// tb_lut_banked: directed self-checking bench for lut_banked at default parameters
module tb_lut_banked;
    logic        clk = 0;
    logic        reset_n, clear, wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  rd_en;
    logic [15:0] rd_addr;
    logic [31:0] q;
    logic [1:0]  q_valid;
    logic        ready;
    int checks = 0, errors = 0, n;

    lut_banked dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .q(q), .q_valid(q_valid), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        clear = 0; wr_en = 0; wr_addr = 0; wr_data = 0; rd_en = 0; rd_addr = 0;
    endtask

    task automatic wait_ready(input int start, input string tag);
        n = start;
        while (ready !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk(tag, 64'(n), 64'd256);
    endtask

    initial begin
        idle();
        reset_n = 0;
        tick(); tick();
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_q", 64'(q), 64'd0);
        chk("rst_qv", 64'(q_valid), 64'd0);
        reset_n = 1;
        wait_ready(0, "init_sweep_len");

        rd_en = 2'b11; rd_addr = {8'h7F, 8'h00};
        tick();
        chk("init_rd_q", 64'(q), 64'd0);
        chk("init_rd_qv", 64'(q_valid), 64'd3);
        rd_addr = {8'hFF, 8'hFF};
        tick();
        chk("init_rd_ff_q", 64'(q), 64'd0);
        chk("init_rd_ff_qv", 64'(q_valid), 64'd3);

        idle();
        wr_en = 1; wr_addr = 8'h10; wr_data = 16'h1234;
        tick();
        wr_addr = 8'h11; wr_data = 16'hBEEF;
        tick();
        idle();
        rd_en = 2'b11; rd_addr = {8'h11, 8'h10};
        tick();
        chk("wr_rd_q", 64'(q), 64'hBEEF1234);
        chk("wr_rd_qv", 64'(q_valid), 64'd3);

        idle();
        wr_en = 1; wr_addr = 8'h20; wr_data = 16'hA5A5;
        rd_en = 2'b11; rd_addr = {8'h20, 8'h20};
        tick();
        chk("bypass_q", 64'(q), 64'hA5A5A5A5);

        idle();
        rd_en = 2'b01; rd_addr = {8'h20, 8'h10};
        tick();
        chk("p0only_qv", 64'(q_valid), 64'd1);
        chk("p0only_q", 64'(q), 64'hA5A51234);
        idle();
        tick();
        chk("nord_qv", 64'(q_valid), 64'd0);
        chk("nord_q", 64'(q), 64'hA5A51234);

        clear = 1;
        tick();
        idle();
        chk("clr_ready", 64'(ready), 64'd0);
        wr_en = 1; wr_addr = 8'h30; wr_data = 16'h5555;
        rd_en = 2'b11; rd_addr = {8'h10, 8'h10};
        tick();
        idle();
        chk("sweep_rd_qv", 64'(q_valid), 64'd0);
        chk("sweep_rd_q", 64'(q), 64'hA5A51234);
        wait_ready(1, "clear_sweep_len");
        rd_en = 2'b11; rd_addr = {8'h30, 8'h10};
        tick();
        chk("post_clr_q", 64'(q), 64'd0);
        chk("post_clr_qv", 64'(q_valid), 64'd3);

        idle();
        wr_en = 1; wr_addr = 8'h50; wr_data = 16'hCAFE;
        tick();
        idle();
        rd_en = 2'b11; rd_addr = {8'h50, 8'h50};
        tick();
        chk("pre_rst_q", 64'(q), 64'hCAFECAFE);
        idle();
        clear = 1;
        tick();
        idle();
        for (int i = 0; i < 100; i++) tick();
        chk("mid_sweep_ready", 64'(ready), 64'd0);
        #2 reset_n = 0;
        #1;
        chk("async_rst_q", 64'(q), 64'd0);
        chk("async_rst_qv", 64'(q_valid), 64'd0);
        chk("async_rst_ready", 64'(ready), 64'd0);
        tick();
        reset_n = 1;
        wait_ready(0, "rst_resweep_len");
        rd_en = 2'b11; rd_addr = {8'h50, 8'h50};
        tick();
        chk("post_rst_q", 64'(q), 64'd0);
        chk("post_rst_qv", 64'(q_valid), 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
